// File: rtl/fsgnj_pkg.sv
// fsgnj_pkg -- shared definitions for the FP sign-injection unit.
//   Mode and format encodings, canonical NaN constants, and the
//   combinational sign-inject / NaN-box function used by fsgnj_unit.
//   The function always works on a 64-bit container; FLEN=32 callers
//   take the low half.
package fsgnj_pkg;

    typedef enum logic [1:0] {
        MODE_J   = 2'b00,
        MODE_JN  = 2'b01,
        MODE_JX  = 2'b10,
        MODE_ILL = 2'b11
    } fsgnj_mode_e;

    typedef enum logic {
        FMT_S = 1'b0,
        FMT_D = 1'b1
    } fsgnj_fmt_e;

    localparam logic [31:0] CNAN_S   = 32'h7FC0_0000;
    localparam logic [63:0] CNAN_D   = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] BOX_ONES = 32'hFFFF_FFFF;

    // Sign selection shared by both formats.
    function automatic logic inj_sign(input logic [1:0] mode,
                                      input logic       s1,
                                      input logic       s2);
        logic s;
        case (mode)
            MODE_J:  s = s2;
            MODE_JN: s = ~s2;
            default: s = s1 ^ s2;
        endcase
        return s;
    endfunction

    // is64: the unit is built with FLEN=64 (enables fmt and NaN boxing).
    function automatic logic [63:0] fsgnj_calc(input logic        is64,
                                               input logic [1:0]  mode,
                                               input logic        fmt,
                                               input logic [63:0] rs1,
                                               input logic [63:0] rs2);
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        res = '0;
        a   = rs1[31:0];
        b   = rs2[31:0];
        if (mode == MODE_ILL) begin
            res = '0;
        end else if (is64 && (fmt == FMT_D)) begin
            res = {inj_sign(mode, rs1[63], rs2[63]), rs1[62:0]};
        end else begin
            // Singles held in a 64-bit register must be NaN-boxed; anything
            // else is treated as the canonical NaN before the sign is applied.
            if (is64 && (rs1[63:32] != BOX_ONES)) a = CNAN_S;
            if (is64 && (rs2[63:32] != BOX_ONES)) b = CNAN_S;
            res = {(is64 ? BOX_ONES : 32'h0), inj_sign(mode, a[31], b[31]), a[30:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fsgnj_unit_skid.sv
// fp_skid_buffer -- two-entry valid/ready stage: output register plus one
// skid entry.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream handshake; in_ready is a flop (= skid empty)
//   in_data [W]         : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data [W]        : downstream payload, held while stalled
module fp_skid_buffer #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_vld_q, out_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         rdy_q;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         acc;
    logic         load_out;

    // rdy_q tracks ~skid_vld_q out of reset, so an accept never coincides
    // with a full skid entry and the skid->out move below cannot drop data.
    assign acc      = in_valid & rdy_q;
    assign load_out = ~out_vld_q | out_ready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (load_out) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (acc) begin
                out_d     = in_data;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (acc) begin
            skid_d     = in_data;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= ~skid_vld_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = out_vld_q;
    assign out_data  = out_q;

endmodule

// File: rtl/fsgnj_unit.sv
// fsgnj_unit -- RISC-V FSGNJ/FSGNJN/FSGNJX with a 1-cycle registered result.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake
//   in_mode [2]         : 00 J, 01 JN, 10 JX, 11 illegal
//   in_fmt              : 0 single, 1 double (ignored when FLEN=32)
//   in_rs1/in_rs2 [FLEN]: magnitude source / sign source
//   in_tag [TAG_W]      : destination tag, passed through
//   out_valid/out_ready : result handshake
//   out_rd, out_tag, out_illegal : result, tag, illegal-mode flag
module fsgnj_unit
    import fsgnj_pkg::*;
#(
    parameter int FLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic             in_fmt,
    input  logic [FLEN-1:0]  in_rs1,
    input  logic [FLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  out_rd,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int PW = FLEN + TAG_W + 1;

    logic [63:0]     res64;
    logic [FLEN-1:0] rd;
    logic            ill;
    logic [PW-1:0]   pkt_in;
    logic [PW-1:0]   pkt_out;

    assign res64 = fsgnj_calc(FLEN == 64, in_mode, in_fmt, 64'(in_rs1), 64'(in_rs2));
    assign ill   = (in_mode == MODE_ILL);

    generate
        if (FLEN == 64) begin : g_d
            assign rd = res64;
        end else begin : g_s
            logic unused_hi;
            assign rd        = res64[31:0];
            assign unused_hi = ^res64[63:32];
        end
    endgenerate

    assign pkt_in = {ill, in_tag, rd};

    fp_skid_buffer #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pkt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pkt_out)
    );

    assign {out_illegal, out_tag, out_rd} = pkt_out;

endmodule

// File: tb/tb_fsgnj_unit.sv
module tb_fsgnj_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // FLEN=32 instance
    logic        a_in_valid, a_in_ready, a_in_fmt, a_out_valid, a_out_ready, a_out_illegal;
    logic [1:0]  a_in_mode;
    logic [31:0] a_in_rs1, a_in_rs2, a_out_rd;
    logic [4:0]  a_in_tag, a_out_tag;
    // FLEN=64 instance
    logic        b_in_valid, b_in_ready, b_in_fmt, b_out_valid, b_out_ready, b_out_illegal;
    logic [1:0]  b_in_mode;
    logic [63:0] b_in_rs1, b_in_rs2, b_out_rd;
    logic [4:0]  b_in_tag, b_out_tag;

    fsgnj_unit #(.FLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_fmt(a_in_fmt),
        .in_rs1(a_in_rs1), .in_rs2(a_in_rs2), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rd(a_out_rd),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal)
    );

    fsgnj_unit #(.FLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_fmt(b_in_fmt),
        .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rd(b_out_rd),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [1:0] m, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] t);
        a_in_valid = v; a_in_mode = m; a_in_rs1 = r1; a_in_rs2 = r2; a_in_tag = t;
    endtask

    task automatic drv_b(input logic v, input logic [1:0] m, input logic f,
                         input logic [63:0] r1, input logic [63:0] r2, input logic [4:0] t);
        b_in_valid = v; b_in_mode = m; b_in_fmt = f; b_in_rs1 = r1; b_in_rs2 = r2; b_in_tag = t;
    endtask

    initial begin
        int nacc;
        logic [4:0] t;
        drv_a(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        a_in_fmt = 1'b0; a_out_ready = 1'b1;
        drv_b(1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 5'd0);
        b_out_ready = 1'b1;

        // Reset state
        cyc(); cyc();
        chk("rst_in_ready32",  a_in_ready, 0);
        chk("rst_out_valid32", a_out_valid, 0);
        chk("rst_out_rd32",    a_out_rd, 0);
        chk("rst_out_tag32",   a_out_tag, 0);
        chk("rst_out_ill32",   a_out_illegal, 0);
        chk("rst_in_ready64",  b_in_ready, 0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_in_ready32", a_in_ready, 1);
        chk("post_rst_in_ready64", b_in_ready, 1);

        // JN single; fmt ignored for FLEN=32
        a_in_fmt = 1'b1;
        drv_a(1'b1, 2'b01, 32'h4086_6666, 32'h4046_6666, 5'd3);
        cyc();
        chk("jn_valid", a_out_valid, 1);
        chk("jn_rd",    a_out_rd, 64'hC086_6666);
        chk("jn_tag",   a_out_tag, 3);
        chk("jn_ill",   a_out_illegal, 0);
        a_in_fmt = 1'b0;
        drv_a(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        cyc();
        chk("jn_drained", a_out_valid, 0);

        // J then JX back-to-back
        drv_a(1'b1, 2'b00, 32'h40CC_CCCC, 32'hBF00_0000, 5'd1);
        cyc();
        chk("j_rd",    a_out_rd, 64'hC0CC_CCCC);
        chk("j_valid", a_out_valid, 1);
        drv_a(1'b1, 2'b10, 32'hC0CC_CCCC, 32'hBF00_0000, 5'd2);
        cyc();
        chk("jx_rd",    a_out_rd, 64'h40CC_CCCC);
        chk("jx_valid", a_out_valid, 1);
        drv_a(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        cyc();
        chk("jx_drained", a_out_valid, 0);

        // Illegal mode between two legal ones
        drv_a(1'b1, 2'b00, 32'h3F80_0000, 32'h8000_0000, 5'd1);
        cyc();
        chk("seq1_rd",  a_out_rd, 64'hBF80_0000);
        chk("seq1_tag", a_out_tag, 1);
        chk("seq1_ill", a_out_illegal, 0);
        drv_a(1'b1, 2'b11, 32'h1234_5678, 32'hFFFF_FFFF, 5'd2);
        cyc();
        chk("ill_rd",    a_out_rd, 0);
        chk("ill_flag",  a_out_illegal, 1);
        chk("ill_tag",   a_out_tag, 2);
        chk("ill_valid", a_out_valid, 1);
        drv_a(1'b1, 2'b01, 32'h3F80_0000, 32'h8000_0000, 5'd3);
        cyc();
        chk("seq3_rd",  a_out_rd, 64'h3F80_0000);
        chk("seq3_tag", a_out_tag, 3);
        chk("seq3_ill", a_out_illegal, 0);
        drv_a(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        cyc();

        // Backpressure: out_ready low for 3 cycles, in_valid held high
        a_out_ready = 1'b0;
        t = 5'd4;
        nacc = 0;
        drv_a(1'b1, 2'b00, 32'h4000_0000 | 32'(t), 32'h0, t);
        for (int i = 0; i < 3; i++) begin
            logic take;
            take = a_in_ready;
            cyc();
            if (take) begin
                nacc++;
                t = t + 5'd1;
                drv_a(1'b1, 2'b00, 32'h4000_0000 | 32'(t), 32'h0, t);
            end
        end
        chk("bp_accepts",   32'(nacc), 2);
        chk("bp_in_ready",  a_in_ready, 0);
        chk("bp_hold_vld",  a_out_valid, 1);
        chk("bp_hold_rd",   a_out_rd, 64'h4000_0004);
        chk("bp_hold_tag",  a_out_tag, 4);
        a_out_ready = 1'b1;
        cyc();
        chk("bp_drain1_tag", a_out_tag, 5);
        chk("bp_drain1_rd",  a_out_rd, 64'h4000_0005);
        chk("bp_rdy_rise",   a_in_ready, 1);
        cyc();
        chk("bp_drain2_tag", a_out_tag, 6);
        chk("bp_drain2_rd",  a_out_rd, 64'h4000_0006);
        chk("bp_drain2_vld", a_out_valid, 1);
        drv_a(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        cyc();
        chk("bp_empty", a_out_valid, 0);

        // FLEN=64: NaN-boxing and double format
        drv_b(1'b1, 2'b00, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 5'd7);
        cyc();
        chk("box_unboxed_rd",  b_out_rd, 64'hFFFF_FFFF_7FC0_0000);
        chk("box_unboxed_tag", b_out_tag, 7);
        drv_b(1'b1, 2'b01, 1'b1, 64'h3FF0_0000_0000_0000, 64'h0, 5'd8);
        cyc();
        chk("dbl_jn_rd", b_out_rd, 64'hBFF0_0000_0000_0000);
        drv_b(1'b1, 2'b10, 1'b0, 64'hFFFF_FFFF_BF80_0000, 64'hFFFF_FFFF_BF80_0000, 5'd9);
        cyc();
        chk("box_jx_rd", b_out_rd, 64'hFFFF_FFFF_3F80_0000);
        drv_b(1'b1, 2'b11, 1'b1, 64'h1, 64'h2, 5'd10);
        cyc();
        chk("ill64_rd",  b_out_rd, 0);
        chk("ill64_flg", b_out_illegal, 1);
        drv_b(1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 5'd0);
        cyc();
        chk("b_empty", b_out_valid, 0);

        // Reset with both entries full
        a_out_ready = 1'b0;
        drv_a(1'b1, 2'b00, 32'h4000_0010, 32'h0, 5'd10);
        cyc();
        drv_a(1'b1, 2'b00, 32'h4000_0011, 32'h0, 5'd11);
        cyc();
        chk("full_in_ready", a_in_ready, 0);
        chk("full_valid",    a_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", a_out_valid, 0);
        chk("async_rst_ready", a_in_ready, 0);
        chk("async_rst_rd",    a_out_rd, 0);
        drv_a(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        a_out_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rerst_in_ready", a_in_ready, 1);
        chk("rerst_no_stale", a_out_valid, 0);
        cyc();
        chk("rerst_no_stale2", a_out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
